// File: rtl/req_gnt_arb_pkg.sv
// Shared types, limits and helpers for the round-robin req/gnt arbiter.
// Optional assertions in the top are enabled by defining REQ_GNT_ARB_ASSERT_EN.
package req_gnt_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT  = 2'd1,
      HOLD = 2'd2
   } arb_state_e;

   localparam int MAX_REQ  = 16;
   localparam int MAX_ID_W = 4;

   // OR-encoder: exact for one-hot input, returns 0 for an all-zero vector.
   function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | MAX_ID_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: first set candidate at or after ptr+1,
// wrapping modulo NUM_REQ.
module rr_priority_sel
   import req_gnt_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] cand,
   input  logic [ID_W-1:0]    ptr,
   output logic               valid,
   output logic [ID_W-1:0]    idx,
   output logic [NUM_REQ-1:0] onehot
);

   logic [ID_W-1:0] pos;

   always_comb begin
      onehot = '0;
      valid  = 1'b0;
      pos    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = ID_W'((int'(ptr) + 1 + k) % NUM_REQ);
         if (!valid && cand[pos]) begin
            onehot[pos] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

   assign idx = ID_W'(onehot_to_idx(MAX_REQ'(onehot)));

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin req/gnt pulse arbiter with a post-grant hold window.
// Define REQ_GNT_ARB_ASSERT_EN to embed protocol and starvation assertions.
module req_gnt_arbiter
   import req_gnt_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int HOLD_CYC = 1,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic               clk_ip,
   input  logic               reset_n_ip,
   input  logic [NUM_REQ-1:0] req_ip,
   output logic [NUM_REQ-1:0] gnt_op,
   output logic [ID_W-1:0]    gnt_id_op,
   output logic               busy_op,
   output logic [NUM_REQ-1:0] pend_op
);

   localparam logic [3:0]      HOLD_M1  = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;
   localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  pend_q, pend_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]     gnt_id_q, gnt_id_d;

   logic [NUM_REQ-1:0]  cand;
   logic                sel_valid;
   logic [ID_W-1:0]     sel_idx;
   logic [NUM_REQ-1:0]  sel_onehot;
   logic                issue;

   // Fresh requests compete only in IDLE; otherwise they wait in pend.
   assign cand = (state_q == IDLE) ? (pend_q | req_ip) : pend_q;

   rr_priority_sel #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_sel (
      .cand   (cand),
      .ptr    (ptr_q),
      .valid  (sel_valid),
      .idx    (sel_idx),
      .onehot (sel_onehot)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      gnt_d    = '0;
      gnt_id_d = gnt_id_q;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               issue    = 1'b1;
               gnt_d    = sel_onehot;
               gnt_id_d = sel_idx;
               ptr_d    = sel_idx;
               state_d  = GNT;
            end
         end
         GNT: begin
            if (HOLD_CYC == 0) begin
               state_d = IDLE;
            end else begin
               cnt_d   = HOLD_M1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A request during its own GNT cycle is kept as a new pending entry.
      pend_d = (pend_q | req_ip) & ~(issue ? sel_onehot : '0);
   end

   always_ff @(posedge clk_ip or negedge reset_n_ip) begin
      if (!reset_n_ip) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         ptr_q    <= PTR_INIT;
         pend_q   <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         pend_q   <= pend_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   assign gnt_op    = gnt_q;
   assign gnt_id_op = gnt_id_q;
   assign busy_op   = (state_q != IDLE);
   assign pend_op   = pend_q;

`ifdef REQ_GNT_ARB_ASSERT_EN
   localparam int STARVE_CYC = NUM_REQ * (HOLD_CYC + 2);

   a_gnt_onehot: assert property (@(posedge clk_ip) disable iff (!reset_n_ip)
      $onehot0(gnt_op))
      else $display("@%0dns a_gnt_onehot Failed", $time);

   a_gnt_pulse: assert property (@(posedge clk_ip) disable iff (!reset_n_ip)
      (gnt_op != '0) |=> (gnt_op == '0))
      else $display("@%0dns a_gnt_pulse Failed", $time);

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_port_chk
      a_gnt_src: assert property (@(posedge clk_ip) disable iff (!reset_n_ip)
         gnt_op[i] |-> $past(pend_q[i] | req_ip[i]))
         else $display("@%0dns a_gnt_src Failed", $time);

      a_no_starve: assert property (@(posedge clk_ip) disable iff (!reset_n_ip)
         req_ip[i] |-> ##[1:STARVE_CYC] gnt_op[i])
         else $display("@%0dns a_no_starve Failed", $time);
   end
`endif

endmodule
